// File: rtl/errsweep_pkg.sv
// ---------------------------------------------------------------------------
// errsweep_pkg
// Shared types and width helpers for the approximate-adder error sweep monitor.
//   state_t : sweep controller states
//   vec_w   : netlist input vector width for IN_W-bit operands
//   sum_w   : width of the |error| sum; wide enough that a full sweep never wraps
//   cnt_w   : width of the violation counter; holds the full vector count
// ---------------------------------------------------------------------------
package errsweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int vec_w(input int in_w);
        return 2 * in_w;
    endfunction

    // Every |error| fits in OUT_W bits and there are 2^(2*IN_W) vectors.
    function automatic int sum_w(input int in_w, input int out_w);
        return out_w + 2 * in_w;
    endfunction

    // One extra bit so that "every vector violates" is representable.
    function automatic int cnt_w(input int in_w);
        return 2 * in_w + 1;
    endfunction

endpackage

// File: rtl/errsweep_abs_err.sv
// ---------------------------------------------------------------------------
// errsweep_abs_err
// Combinational error evaluation for one captured netlist vector.
// Ports:
//   a       in  IN_W   operand A of the vector
//   b       in  IN_W   operand B of the vector
//   dut_res in  OUT_W  approximate sum produced by the netlist
//   err     out OUT_W  |dut_res - (a+b)|
//   viol    out 1      err > ET
// ---------------------------------------------------------------------------
module errsweep_abs_err
    import errsweep_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int OUT_W = 3,
    parameter int ET    = 2
) (
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [OUT_W-1:0] dut_res,
    output logic [OUT_W-1:0] err,
    output logic             viol
);

    localparam logic [OUT_W-1:0] ET_V = OUT_W'(ET);

    // Magnitude of a signed difference, truncated back to the netlist width.
    function automatic logic [OUT_W-1:0] abs_trunc(input logic signed [OUT_W:0] d);
        return OUT_W'((d < 0) ? -d : d);
    endfunction

    logic        [OUT_W-1:0] exact;
    logic signed [OUT_W:0]   diff;

    assign exact = OUT_W'(a) + OUT_W'(b);
    // One extra bit so both operands stay non-negative before subtracting.
    assign diff  = $signed({1'b0, dut_res}) - $signed({1'b0, exact});
    assign err   = abs_trunc(diff);
    assign viol  = (err > ET_V);

endmodule

// File: rtl/approx_err_sweep_monitor.sv
// ---------------------------------------------------------------------------
// approx_err_sweep_monitor
// Exhaustively sweeps every input vector into an external combinational
// approximate adder and accumulates its error against the exact sum.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a sweep (accepted only in IDLE)
//   abort           return to IDLE at the next edge, no done pulse
//   busy            high while sweeping or draining
//   done            one-cycle pulse when results are valid
//   vec_out         vector to the netlist: [IN_W-1:0]=A, [2*IN_W-1:IN_W]=B
//   dut_res         netlist output for vec_out
//   max_err         largest |error| seen
//   err_sum         sum of |error| over all vectors
//   viol_cnt        number of vectors with |error| > ET
//   pass            viol_cnt == 0, valid from done until the next start
// Optional (macro ERRSWEEP_FIRST_FAIL_EN):
//   first_fail_vec  first violating vector of the sweep
//   first_fail_vld  first_fail_vec holds a captured violation
// ---------------------------------------------------------------------------
module approx_err_sweep_monitor
    import errsweep_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int OUT_W = 3,
    parameter int ET    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [2*IN_W-1:0]       vec_out,
    input  logic [OUT_W-1:0]        dut_res,
    output logic [OUT_W-1:0]        max_err,
    output logic [OUT_W+2*IN_W-1:0] err_sum,
    output logic [2*IN_W:0]         viol_cnt,
    output logic                    pass
`ifdef ERRSWEEP_FIRST_FAIL_EN
    ,
    output logic [2*IN_W-1:0]       first_fail_vec,
    output logic                    first_fail_vld
`endif
);

    localparam int VEC_W = vec_w(IN_W);
    localparam int SUM_W = sum_w(IN_W, OUT_W);
    localparam int CNT_W = cnt_w(IN_W);
    localparam logic [VEC_W-1:0] VEC_MAX = '1;

    state_t            state_q, state_d;
    logic              clr, cap_en, done_d;
    logic [VEC_W-1:0]  vec_q;
    logic              done_q, pass_q;

    logic              vld_p1_q;
    logic [VEC_W-1:0]  cap_vec_p1_q;
    logic [OUT_W-1:0]  cap_res_p1_q;
    logic [OUT_W-1:0]  err_p1;
    logic              viol_p1;

    logic [OUT_W-1:0]  max_err_q;
    logic [SUM_W-1:0]  err_sum_q;
    logic [CNT_W-1:0]  viol_cnt_q;

    // Controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        cap_en  = 1'b0;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SWEEP;
                        clr     = 1'b1;
                    end
                end
                SWEEP: begin
                    cap_en = 1'b1;
                    // The all-ones vector is being captured this edge; stop
                    // without driving a wrapped vector back to the netlist.
                    if (vec_q == VEC_MAX) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    state_d = DONE;
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Vector counter and done/pass flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (clr) begin
                vec_q  <= '0;
                pass_q <= 1'b0;
            end else begin
                if (cap_en && (vec_q != VEC_MAX)) begin
                    vec_q <= vec_q + 1'b1;
                end
                if (done_d) begin
                    pass_q <= (viol_cnt_q == '0);
                end
            end
        end
    end

    // ---- stage p1: capture {vector, netlist result} ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= cap_en;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cap_vec_p1_q <= '0;
            cap_res_p1_q <= '0;
        end else if (cap_en) begin
            cap_vec_p1_q <= vec_q;
            cap_res_p1_q <= dut_res;
        end
    end

    errsweep_abs_err #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ET    (ET)
    ) u_abs_err (
        .a       (cap_vec_p1_q[IN_W-1:0]),
        .b       (cap_vec_p1_q[2*IN_W-1:IN_W]),
        .dut_res (cap_res_p1_q),
        .err     (err_p1),
        .viol    (viol_p1)
    );

    // ---- stage p2: accumulate ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_err_q  <= '0;
            err_sum_q  <= '0;
            viol_cnt_q <= '0;
        end else if (clr) begin
            max_err_q  <= '0;
            err_sum_q  <= '0;
            viol_cnt_q <= '0;
        end else if (vld_p1_q) begin
            if (err_p1 > max_err_q) begin
                max_err_q <= err_p1;
            end
            err_sum_q  <= err_sum_q + SUM_W'(err_p1);
            viol_cnt_q <= viol_cnt_q + CNT_W'(viol_p1);
        end
    end

`ifdef ERRSWEEP_FIRST_FAIL_EN
    logic [VEC_W-1:0] ff_vec_q;
    logic             ff_vld_q;

    // Only the earliest violation of a sweep is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vec_q <= '0;
            ff_vld_q <= 1'b0;
        end else if (clr) begin
            ff_vec_q <= '0;
            ff_vld_q <= 1'b0;
        end else if (vld_p1_q && viol_p1 && !ff_vld_q) begin
            ff_vec_q <= cap_vec_p1_q;
            ff_vld_q <= 1'b1;
        end
    end

    assign first_fail_vec = ff_vec_q;
    assign first_fail_vld = ff_vld_q;
`else
    // First-fail capture not built.
`endif

    assign busy     = (state_q == SWEEP) || (state_q == DRAIN);
    assign done     = done_q;
    assign vec_out  = vec_q;
    assign max_err  = max_err_q;
    assign err_sum  = err_sum_q;
    assign viol_cnt = viol_cnt_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_approx_err_sweep_monitor.sv
module tb_approx_err_sweep_monitor;

    localparam int IN_W  = 2;
    localparam int OUT_W = 3;
    localparam int ET    = 2;
    localparam int NV    = 16;
    localparam int LAT   = 18;

    typedef struct {
        int max_e;
        int sum;
        int viol;
        int pass_e;
        int ffv;
        int ffvld;
        int start_edge;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic                    abort;
    logic                    busy;
    logic                    done;
    logic [2*IN_W-1:0]       vec_out;
    logic [OUT_W-1:0]        dut_res;
    logic [OUT_W-1:0]        max_err;
    logic [OUT_W+2*IN_W-1:0] err_sum;
    logic [2*IN_W:0]         viol_cnt;
    logic                    pass;
`ifdef ERRSWEEP_FIRST_FAIL_EN
    logic [2*IN_W-1:0]       first_fail_vec;
    logic                    first_fail_vld;
`endif

    int   mode;       // 0 exact adder, 1 stuck at 0, 2 stuck at 7
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   s;
    int   d0;
    exp_t sb[$];
    exp_t cur;

    approx_err_sweep_monitor #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ET    (ET)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .vec_out        (vec_out),
        .dut_res        (dut_res),
        .max_err        (max_err),
        .err_sum        (err_sum),
        .viol_cnt       (viol_cnt),
        .pass           (pass)
`ifdef ERRSWEEP_FIRST_FAIL_EN
        ,
        .first_fail_vec (first_fail_vec),
        .first_fail_vld (first_fail_vld)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Netlist stand-in
    function automatic logic [OUT_W-1:0] approx(input int m, input logic [2*IN_W-1:0] v);
        case (m)
            0:       return {1'b0, v[1:0]} + {1'b0, v[3:2]};
            1:       return 3'd0;
            default: return 3'd7;
        endcase
    endfunction

    always_comb dut_res = approx(mode, vec_out);

    // Expected results for a whole sweep in a given model mode
    function automatic exp_t build_exp(input int m);
        exp_t e;
        int a, b, ex, ap, d;
        e.max_e = 0; e.sum = 0; e.viol = 0; e.ffv = 0; e.ffvld = 0; e.start_edge = 0;
        for (int v = 0; v < NV; v++) begin
            a  = v % 4;
            b  = v / 4;
            ex = a + b;
            ap = (m == 0) ? ex : ((m == 1) ? 0 : 7);
            d  = ap - ex;
            if (d < 0) d = -d;
            if (d > e.max_e) e.max_e = d;
            e.sum = e.sum + d;
            if (d > ET) begin
                e.viol = e.viol + 1;
                if (e.ffvld == 0) begin
                    e.ffvld = 1;
                    e.ffv   = v;
                end
            end
        end
        e.pass_e = (e.viol == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: one expected entry per done pulse
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                cur = sb.pop_front();
                check("latency",  cyc - cur.start_edge, LAT);
                check("max_err",  max_err,  cur.max_e);
                check("err_sum",  err_sum,  cur.sum);
                check("viol_cnt", viol_cnt, cur.viol);
                check("pass",     pass,     cur.pass_e);
                check("busy_at_done", busy, 0);
`ifdef ERRSWEEP_FIRST_FAIL_EN
                check("first_fail_vec", first_fail_vec, cur.ffv);
                check("first_fail_vld", first_fail_vld, cur.ffvld);
`endif
            end
        end
    end

    task automatic do_start(output int sc);
        exp_t e;
        e = build_exp(mode);
        sc = cyc;
        e.start_edge = cyc + 1;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        int i;
        i = 0;
        while (done_cnt == n0 && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (done_cnt == n0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        check("rst_vec_out",  vec_out,  0);
        check("rst_max_err",  max_err,  0);
        check("rst_err_sum",  err_sum,  0);
        check("rst_viol_cnt", viol_cnt, 0);
        check("rst_pass",     pass,     0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: exact adder
        mode = 0; d0 = done_cnt;
        do_start(s);
        check("sweep_busy", busy, 1);
        wait_done(d0);
        repeat (5) @(negedge clk);
        check("hold_pass", pass, 1);

        // 2: stuck at 0
        mode = 1; d0 = done_cnt;
        do_start(s);
        wait_done(d0);
        repeat (4) @(negedge clk);
        check("hold_viol", viol_cnt, 10);
        check("hold_sum",  err_sum,  48);

        // 3: stuck at 7
        mode = 2; d0 = done_cnt;
        do_start(s);
        wait_done(d0);
        repeat (2) @(negedge clk);

        // 4: start pulses during SWEEP and DONE are ignored
        mode = 0; d0 = done_cnt;
        do_start(s);
        wait_until(s + 5);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_until(s + 18);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (25) @(negedge clk);
        check("single_done", done_cnt, d0 + 1);
        check("sb_empty",    sb.size(), 0);
        check("idle_busy",   busy, 0);

        // 5a: asynchronous reset mid-sweep
        mode = 1; d0 = done_cnt;
        do_start(s);
        wait_until(s + 7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",     busy,     0);
        check("arst_done",     done,     0);
        check("arst_vec_out",  vec_out,  0);
        check("arst_max_err",  max_err,  0);
        check("arst_err_sum",  err_sum,  0);
        check("arst_viol_cnt", viol_cnt, 0);
        check("arst_pass",     pass,     0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("arst_no_done", done_cnt, d0);
        d0 = done_cnt;
        do_start(s);
        wait_done(d0);
        repeat (2) @(negedge clk);

        // 5b: abort mid-sweep
        mode = 0; d0 = done_cnt;
        do_start(s);
        wait_until(s + 5);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        repeat (25) @(negedge clk);
        check("abort_no_done", done_cnt, d0);

        // start together with abort: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_wins_busy", busy, 0);
        repeat (25) @(negedge clk);
        check("abort_wins_no_done", done_cnt, d0);

        // 6: back-to-back sweeps, exact then stuck at 0
        mode = 0; d0 = done_cnt;
        do_start(s);
        wait_done(d0);
        check("b2b_done_high", done, 1);
        mode = 1; d0 = done_cnt;
        do_start(s);
        check("b2b_busy",       busy,     1);
        check("b2b_clear_pass", pass,     0);
        check("b2b_clear_sum",  err_sum,  0);
        wait_done(d0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
